// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_if
//  Description : Byte-stream input and instruction-memory write bus of the
//                serial boot loader, plus its CPU-reset and status outputs.
//                Slave modport is the loader, master modport its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  err;

    modport slave (
        input  byte_in,
        input  byte_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_rst,
        output done,
        output err
    );

    modport master (
        output byte_in,
        output byte_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_rst,
        input  done,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Serial boot loader. Takes the uart receiver byte stream,
//                parses a frame of {N (4 bytes LE), N words (4 bytes LE each)}
//                and writes the words to instruction memory from BASE_ADDR.
//                Holds the CPU in reset until a complete, valid frame landed.
//                Optional macro UART_LOADER_CHECKSUM_EN adds a trailing
//                XOR checksum byte over the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 1024
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_loader_if.slave    bus
);

    // Counter width large enough to hold MAX_WORDS itself.
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_bv_q;
    logic                  r_armed;
    logic [1:0]            r_idx;
    logic [23:0]           r_asm;
    logic [CW-1:0]         r_n;
    logic [CW-1:0]         r_wcnt;
    logic                  r_last;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_err;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  w_ev;
    logic [31:0]           w_word;
    logic                  w_len_bad;
    logic [ADDR_WIDTH-1:0] w_addr;

    // One event per rising edge of the level flag; a level already high when
    // reset is released must first drop (r_armed) before it can count.
    assign w_ev      = bus.byte_valid & ~r_bv_q & r_armed;
    // The 4th byte goes straight into the top lane, no need to store it.
    assign w_word    = {bus.byte_in, r_asm};
    assign w_len_bad = (w_word > 32'(MAX_WORDS));
    assign w_addr    = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_wcnt);

    // Rising-edge detector for the uart byte_read level flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bv_q  <= 1'b0;
            r_armed <= ~bus.byte_valid;
        end else begin
            r_bv_q <= bus.byte_valid;
            if (!bus.byte_valid) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame parser, word assembler and memory writer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LEN;
            r_idx       <= 2'd0;
            r_asm       <= 24'd0;
            r_n         <= '0;
            r_wcnt      <= '0;
            r_last      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_LEN: begin
`ifdef UART_LOADER_CHECKSUM_EN
                    r_csum <= 8'd0;
`endif
                    if (w_ev) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_asm[7:0]   <= bus.byte_in;
                            2'd1: r_asm[15:8]  <= bus.byte_in;
                            2'd2: r_asm[23:16] <= bus.byte_in;
                            default: begin
                                if (w_word == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                    r_state <= S_CSUM;
`else
                                    r_state   <= S_DONE;
                                    r_done    <= 1'b1;
                                    r_cpu_rst <= 1'b0;
`endif
                                end else if (w_len_bad) begin
                                    r_state <= S_ERR;
                                    r_err   <= 1'b1;
                                end else begin
                                    r_n     <= CW'(w_word);
                                    r_wcnt  <= '0;
                                    r_last  <= 1'b0;
                                    r_state <= S_DATA;
                                end
                            end
                        endcase
                    end
                end

                S_DATA: begin
                    // The final strobe is on the bus this cycle; finish next.
                    if (r_mem_we && r_last) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b0;
`endif
                    end else if (w_ev) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.byte_in;
`endif
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_asm[7:0]   <= bus.byte_in;
                            2'd1: r_asm[15:8]  <= bus.byte_in;
                            2'd2: r_asm[23:16] <= bus.byte_in;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_addr;
                                r_mem_wdata <= w_word;
                                r_wcnt      <= r_wcnt + CW'(1);
                                r_last      <= ((r_wcnt + CW'(1)) == r_n);
                            end
                        endcase
                    end
                end

`ifdef UART_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_ev) begin
                        if (bus.byte_in == r_csum) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif

                // Terminal states: only rst leaves them.
                S_DONE: begin
                end

                S_ERR: begin
                end

                default: begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rst   = r_cpu_rst;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
